// File: rtl/reset_sequencer.sv
// Staggered per-channel reset release with optional per-channel ack handshake.
// Define RST_SEQ_ACK_EN to compile in the ack wait / timeout path.
//
// state    | meaning
// HOLD     | all channels held in reset, counting the hold window
// RELEASE  | a channel was just released on the previous edge
// WAIT_ACK | waiting for ch_ack of the released channel (ack build only)
// STAGGER  | spacing before the next release
// DONE     | all enabled channels released
module reset_sequencer #(
  parameter int NUM_CH         = 4,
  parameter int HOLD_CYCLES    = 8,
  parameter int STAGGER_CYCLES = 2,
  parameter int ACK_TIMEOUT    = 16,
  localparam int IW            = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              sw_rst_req,
  input  logic [NUM_CH-1:0] ch_mask,
  input  logic [NUM_CH-1:0] ch_ack,
  output logic [NUM_CH-1:0] ch_rst_n,
  output logic              seq_busy,
  output logic              seq_done,
  output logic              err,
  output logic [IW-1:0]     err_ch
);

  localparam int MAX_HS = (HOLD_CYCLES > STAGGER_CYCLES) ? HOLD_CYCLES : STAGGER_CYCLES;
  localparam int MAXC   = (MAX_HS > ACK_TIMEOUT) ? MAX_HS : ACK_TIMEOUT;
  localparam int CW     = $clog2(MAXC + 1) + 1;

  typedef enum logic [2:0] {HOLD, RELEASE, WAIT_ACK, STAGGER, DONE} state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [IW-1:0]     cur_q, cur_d;
  logic [NUM_CH-1:0] mask_q, mask_d;
  logic [NUM_CH-1:0] rst_n_d;
  logic              busy_d, done_d, err_d;
  logic [IW-1:0]     err_ch_d;
  logic              adv, found;
  logic [IW-1:0]     nxt;
  int                from_idx;

`ifndef RST_SEQ_ACK_EN
  logic unused_ack;
  assign unused_ack = ^ch_ack;
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= HOLD;
      cnt_q    <= '0;
      cur_q    <= '0;
      mask_q   <= ch_mask;
      ch_rst_n <= '0;
      seq_busy <= 1'b0;
      seq_done <= 1'b0;
      err      <= 1'b0;
      err_ch   <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      cur_q    <= cur_d;
      mask_q   <= mask_d;
      ch_rst_n <= rst_n_d;
      seq_busy <= busy_d;
      seq_done <= done_d;
      err      <= err_d;
      err_ch   <= err_ch_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    cur_d    = cur_q;
    mask_d   = mask_q;
    rst_n_d  = ch_rst_n;
    busy_d   = seq_busy;
    done_d   = seq_done;
    err_d    = err;
    err_ch_d = err_ch;
    adv      = 1'b0;
    found    = 1'b0;
    nxt      = '0;

    // Lowest enabled channel above the current one; masked channels cost no cycles.
    from_idx = (state_q == HOLD) ? 0 : int'(cur_q) + 1;
    for (int i = 0; i < NUM_CH; i++) begin
      if (!found && i >= from_idx && mask_q[i]) begin
        found = 1'b1;
        nxt   = IW'(i);
      end
    end

    case (state_q)
      HOLD: begin
        busy_d = 1'b1;
        if (cnt_q == CW'(HOLD_CYCLES)) adv = 1'b1;
        else cnt_d = cnt_q + 1'b1;
      end
`ifdef RST_SEQ_ACK_EN
      RELEASE, WAIT_ACK: begin
        if (ch_ack[cur_q]) begin
          state_d = STAGGER;
          cnt_d   = CW'(1);
        end else if (cnt_q == CW'(ACK_TIMEOUT - 1)) begin
          err_d    = 1'b1;
          err_ch_d = cur_q;
          state_d  = STAGGER;
          cnt_d    = CW'(1);
        end else begin
          state_d = WAIT_ACK;
          cnt_d   = cnt_q + 1'b1;
        end
      end
      STAGGER: begin
`else
      RELEASE, STAGGER: begin
`endif
        if (cnt_q == CW'(STAGGER_CYCLES)) adv = 1'b1;
        else begin
          state_d = STAGGER;
          cnt_d   = cnt_q + 1'b1;
        end
      end
      DONE: ;
      default: state_d = HOLD;
    endcase

    if (adv) begin
      if (found) begin
        rst_n_d[nxt] = 1'b1;
        cur_d        = nxt;
        state_d      = RELEASE;
`ifdef RST_SEQ_ACK_EN
        cnt_d        = '0;
`else
        cnt_d        = CW'(1);
`endif
      end else begin
        state_d = DONE;
        busy_d  = 1'b0;
        done_d  = 1'b1;
      end
    end

    if (sw_rst_req) begin
      state_d = HOLD;
      cnt_d   = '0;
      cur_d   = '0;
      mask_d  = ch_mask;
      rst_n_d = '0;
      busy_d  = 1'b1;
      done_d  = 1'b0;
      err_d   = 1'b0;
    end

`ifndef RST_SEQ_ACK_EN
    err_d    = 1'b0;
    err_ch_d = '0;
`endif
  end

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench for reset_sequencer at default parameters; edge numbers are
// counted from the first edge after reset release or after a software restart edge.
module tb_reset_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       sw_rst_req;
  logic [3:0] ch_mask;
  logic [3:0] ch_ack;
  logic [3:0] ch_rst_n;
  logic       seq_busy;
  logic       seq_done;
  logic       err;
  logic [1:0] err_ch;

  int tests = 0;
  int fails = 0;
  int rel   = 0;

  reset_sequencer dut (
    .clk        (clk),
    .reset      (reset),
    .sw_rst_req (sw_rst_req),
    .ch_mask    (ch_mask),
    .ch_ack     (ch_ack),
    .ch_rst_n   (ch_rst_n),
    .seq_busy   (seq_busy),
    .seq_done   (seq_done),
    .err        (err),
    .err_ch     (err_ch)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
    rel++;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s edge %0d: observed %0h expected %0h", tag, rel, obs, exp);
    end
  endtask

  task automatic chk_restart();
    chk("restart_rst_n", 32'(ch_rst_n), 32'h0);
    chk("restart_busy",  32'(seq_busy), 32'h1);
    chk("restart_done",  32'(seq_done), 32'h0);
    chk("restart_err",   32'(err),      32'h0);
  endtask

  task automatic sw_pulse();
    sw_rst_req = 1'b1;
    tick();
    sw_rst_req = 1'b0;
    rel = 0;
    chk_restart();
  endtask

  // r0..r3: edge where each channel rises (0 = never); done_e: edge seq_done rises.
  task automatic check_seq(input int r0, input int r1, input int r2, input int r3,
                           input int done_e, input int n);
    int rise [4];
    logic [3:0] exp_rst;
    rise = '{r0, r1, r2, r3};
    for (int e = 1; e <= n; e++) begin
      tick();
      exp_rst = '0;
      for (int i = 0; i < 4; i++)
        if (rise[i] > 0 && e >= rise[i]) exp_rst[i] = 1'b1;
      chk("seq_rst_n", 32'(ch_rst_n), 32'(exp_rst));
      chk("seq_done",  32'(seq_done), (e >= done_e) ? 32'h1 : 32'h0);
      chk("seq_busy",  32'(seq_busy), (e >= done_e) ? 32'h0 : 32'h1);
      chk("seq_err",   32'(err),      32'h0);
    end
  endtask

  initial begin
    reset      = 1'b0;
    sw_rst_req = 1'b0;
    ch_mask    = 4'b1111;
    ch_ack     = 4'b0000;
    tick();
    tick();
    chk("rst_rst_n", 32'(ch_rst_n), 32'h0);
    chk("rst_busy",  32'(seq_busy), 32'h0);
    chk("rst_done",  32'(seq_done), 32'h0);
    chk("rst_err",   32'(err),      32'h0);
    chk("rst_errch", 32'(err_ch),   32'h0);
    reset = 1'b1;
    rel   = 0;

`ifdef RST_SEQ_ACK_EN
    // ch1 never acks: timeout 16 edges after its release, ch2 follows 2 edges later.
    ch_ack = 4'b1101;
    for (int e = 1; e <= 40; e++) begin
      tick();
      if (e == 9)  chk("ack_ch0",      32'(ch_rst_n), 32'h1);
      if (e == 11) chk("ack_ch1_wait", 32'(ch_rst_n), 32'h1);
      if (e == 12) chk("ack_ch1",      32'(ch_rst_n), 32'h3);
      if (e == 27) chk("ack_err_pre",  32'(err),      32'h0);
      if (e == 28) begin
        chk("ack_err",   32'(err),    32'h1);
        chk("ack_errch", 32'(err_ch), 32'h1);
      end
      if (e == 29) chk("ack_ch2_pre",  32'(ch_rst_n), 32'h3);
      if (e == 30) chk("ack_ch2",      32'(ch_rst_n), 32'h7);
      if (e == 33) chk("ack_ch3",      32'(ch_rst_n), 32'hf);
      if (e == 35) chk("ack_done_pre", 32'(seq_done), 32'h0);
      if (e == 36) begin
        chk("ack_done", 32'(seq_done), 32'h1);
        chk("ack_busy", 32'(seq_busy), 32'h0);
        chk("ack_err_sticky", 32'(err), 32'h1);
      end
    end

    // Ack arrives exactly on the 16th wait edge: ack wins, no error.
    ch_mask = 4'b0010;
    ch_ack  = 4'b0000;
    sw_pulse();
    for (int e = 1; e <= 30; e++) begin
      tick();
      if (e == 24) ch_ack = 4'b0010;
      if (e == 25) ch_ack = 4'b0000;
      if (e == 9)  chk("ack16_ch1",  32'(ch_rst_n), 32'h2);
      if (e == 25) chk("ack16_err",  32'(err),      32'h0);
      if (e == 26) begin
        chk("ack16_err2", 32'(err),      32'h0);
        chk("ack16_pre",  32'(seq_done), 32'h0);
      end
      if (e == 27) chk("ack16_done", 32'(seq_done), 32'h1);
      if (e == 30) chk("ack16_err3", 32'(err),      32'h0);
    end
`else
    // Full mask: releases at 9, 11, 13, 15; done at 17.
    check_seq(9, 11, 13, 15, 17, 20);

    // Sparse mask; the later mask change must be ignored until the next restart.
    ch_mask = 4'b1010;
    sw_pulse();
    ch_mask = 4'b1111;
    check_seq(0, 9, 0, 11, 13, 16);

    // Nothing enabled: done at the end of the hold window, no release.
    ch_mask = 4'b0000;
    sw_pulse();
    check_seq(0, 0, 0, 0, 9, 12);

    // Software restart sampled at edge 12: ch0 comes back at edge 21.
    ch_mask = 4'b1111;
    sw_pulse();
    check_seq(9, 11, 0, 0, 100, 11);
    sw_pulse();
    check_seq(9, 11, 13, 15, 17, 18);

    // Hardware reset at edge 12 aborts; a full sequence replays afterwards.
    sw_pulse();
    check_seq(9, 11, 0, 0, 100, 11);
    reset = 1'b0;
    tick();
    chk("abort_rst_n", 32'(ch_rst_n), 32'h0);
    chk("abort_busy",  32'(seq_busy), 32'h0);
    chk("abort_done",  32'(seq_done), 32'h0);
    chk("abort_err",   32'(err),      32'h0);
    chk("abort_errch", 32'(err_ch),   32'h0);
    reset = 1'b1;
    rel   = 0;
    check_seq(9, 11, 13, 15, 17, 18);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
